// File: rtl/grid_board_if.sv
// Move handshake between a player/AI front end and grid_board.
// The master issues move requests; the slave (grid_board) reports ready/accept/reject.
interface grid_board_if #(
    parameter int IDX_W = 4
);
    logic             move_valid;
    logic [IDX_W-1:0] move_idx;
    logic             move_ready;
    logic             move_accept;
    logic             move_reject;

    modport master (
        output move_valid,
        output move_idx,
        input  move_ready,
        input  move_accept,
        input  move_reject
    );

    modport slave (
        input  move_valid,
        input  move_idx,
        output move_ready,
        output move_accept,
        output move_reject
    );
endinterface

// File: rtl/grid_board.sv
// N-in-a-row board: validates moves, then checks the four lines through the placed cell.
// Define GRID_BOARD_UNDO_EN to add single-level undo of the last accepted move.
module grid_board #(
    parameter int ROWS    = 3,
    parameter int COLS    = 3,
    parameter int WIN_LEN = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    grid_board_if.slave            mv,
    output logic                   turn,
    output logic [2*ROWS*COLS-1:0] board,
    output logic                   game_over,
    output logic [1:0]             winner,
    output logic                   draw
`ifdef GRID_BOARD_UNDO_EN
    ,
    input  logic                   undo,
    output logic                   undo_avail
`endif
);
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int CNT_W = $clog2(CELLS + 1);
    localparam int PW    = $clog2(2 * CELLS);
    localparam int MAXD  = (ROWS > COLS) ? ROWS : COLS;

    typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

    state_t           state_q, state_d;
    logic [1:0]       dir_q;
    logic [IDX_W-1:0] last_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             win_q;
    logic [1:0]       mark;
    logic             hs, legal, hit;
    logic             do_accept, do_reject, fin_win, fin_draw, next_turn;
    int               line_cnt;

`ifdef GRID_BOARD_UNDO_EN
    logic last_mover_q;
    logic undo_req, do_undo;
    assign undo_req = undo && undo_avail;
`endif

    assign mark          = turn ? 2'b10 : 2'b01;
    assign mv.move_ready = (state_q == IDLE) && !reset;
    assign hs            = mv.move_valid && mv.move_ready;
    assign hit           = line_cnt >= WIN_LEN;

    always_comb begin
        legal = 1'b0;
        if (int'(mv.move_idx) < CELLS)
            legal = (board[PW'(2 * int'(mv.move_idx)) +: 2] == 2'b00);
    end

    // Count the mover's consecutive marks along the current direction, both ways,
    // stopping at the first foreign/blank cell or board edge (no wrap).
    always_comb begin
        int  r0, c0, r, c, dr, dc;
        logic run;
        r0 = int'(last_idx_q) / COLS;
        c0 = int'(last_idx_q) % COLS;
        r  = 0;
        c  = 0;
        case (dir_q)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        line_cnt = 1;
        run      = 1'b1;
        for (int unsigned k = 1; k < MAXD; k++) begin
            r = r0 + int'(k) * dr;
            c = c0 + int'(k) * dc;
            if (run && r >= 0 && r < ROWS && c >= 0 && c < COLS &&
                board[PW'(2 * (r * COLS + c)) +: 2] == mark)
                line_cnt++;
            else
                run = 1'b0;
        end
        run = 1'b1;
        for (int unsigned k = 1; k < MAXD; k++) begin
            r = r0 - int'(k) * dr;
            c = c0 - int'(k) * dc;
            if (run && r >= 0 && r < ROWS && c >= 0 && c < COLS &&
                board[PW'(2 * (r * COLS + c)) +: 2] == mark)
                line_cnt++;
            else
                run = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        do_accept = 1'b0;
        do_reject = 1'b0;
        fin_win   = 1'b0;
        fin_draw  = 1'b0;
        next_turn = 1'b0;
`ifdef GRID_BOARD_UNDO_EN
        do_undo   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (legal) begin
                        do_accept = 1'b1;
                        state_d   = CHECK;
                    end else begin
                        do_reject = 1'b1;
                    end
                end
`ifdef GRID_BOARD_UNDO_EN
                else if (undo_req) do_undo = 1'b1;
`endif
            end
            CHECK: begin
                if (dir_q == 2'd3) begin
                    if (win_q || hit) begin
                        fin_win = 1'b1;
                        state_d = OVER;
                    end else if (cnt_q == CNT_W'(CELLS)) begin
                        fin_draw = 1'b1;
                        state_d  = OVER;
                    end else begin
                        next_turn = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            OVER: begin
`ifdef GRID_BOARD_UNDO_EN
                if (undo_req) begin
                    do_undo = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            board          <= '0;
            turn           <= 1'b0;
            cnt_q          <= '0;
            dir_q          <= '0;
            win_q          <= 1'b0;
            last_idx_q     <= '0;
            game_over      <= 1'b0;
            winner         <= 2'b00;
            draw           <= 1'b0;
            mv.move_accept <= 1'b0;
            mv.move_reject <= 1'b0;
`ifdef GRID_BOARD_UNDO_EN
            undo_avail     <= 1'b0;
            last_mover_q   <= 1'b0;
`endif
        end else begin
            mv.move_accept <= do_accept;
            mv.move_reject <= do_reject;
            if (do_accept) begin
                board[PW'(2 * int'(mv.move_idx)) +: 2] <= mark;
                last_idx_q <= mv.move_idx;
                cnt_q      <= cnt_q + CNT_W'(1);
                dir_q      <= '0;
`ifdef GRID_BOARD_UNDO_EN
                undo_avail   <= 1'b1;
                last_mover_q <= turn;
`endif
            end
            if (state_q == CHECK) begin
                dir_q <= dir_q + 2'd1;
                win_q <= (dir_q == 2'd0) ? hit : (win_q | hit);
            end
            if (fin_win) begin
                game_over <= 1'b1;
                winner    <= mark;
            end
            if (fin_draw) begin
                game_over <= 1'b1;
                draw      <= 1'b1;
                winner    <= 2'b00;
            end
            if (next_turn) turn <= ~turn;
`ifdef GRID_BOARD_UNDO_EN
            if (do_undo) begin
                board[PW'(2 * int'(last_idx_q)) +: 2] <= 2'b00;
                cnt_q      <= cnt_q - CNT_W'(1);
                turn       <= last_mover_q;
                game_over  <= 1'b0;
                winner     <= 2'b00;
                draw       <= 1'b0;
                undo_avail <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_grid_board.sv
// Directed self-checking bench for grid_board: a 3x3/3 board and a 5x5/4 board.
// Undo scenario is compiled in when GRID_BOARD_UNDO_EN is defined.
module tb_grid_board;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grid_board_if #(.IDX_W(4)) if3 ();
    grid_board_if #(.IDX_W(5)) if5 ();

    logic        turn3, go3, draw3;
    logic [1:0]  win3;
    logic [17:0] board3;
    logic        turn5, go5, draw5;
    logic [1:0]  win5;
    logic [49:0] board5;
`ifdef GRID_BOARD_UNDO_EN
    logic undo3, ua3, undo5, ua5;
`endif

    int checks = 0;
    int errors = 0;

    grid_board #(.ROWS(3), .COLS(3), .WIN_LEN(3)) u3 (
        .clk(clk), .reset(reset), .mv(if3), .turn(turn3), .board(board3),
        .game_over(go3), .winner(win3), .draw(draw3)
`ifdef GRID_BOARD_UNDO_EN
        , .undo(undo3), .undo_avail(ua3)
`endif
    );

    grid_board #(.ROWS(5), .COLS(5), .WIN_LEN(4)) u5 (
        .clk(clk), .reset(reset), .mv(if5), .turn(turn5), .board(board5),
        .game_over(go5), .winner(win5), .draw(draw5)
`ifdef GRID_BOARD_UNDO_EN
        , .undo(undo5), .undo_avail(ua5)
`endif
    );

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One move on the 3x3 board; lat = cycles after the handshake until ready or game over.
    task automatic mv3(input int idx, output logic acc, output logic rej, output int lat);
        if3.move_valid = 1'b1;
        if3.move_idx   = 4'(idx);
        @(posedge clk); #1;
        acc = if3.move_accept;
        rej = if3.move_reject;
        if3.move_valid = 1'b0;
        lat = 0;
        while (!if3.move_ready && !go3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic mv5(input int idx, output logic acc, output logic rej, output int lat);
        if5.move_valid = 1'b1;
        if5.move_idx   = 5'(idx);
        @(posedge clk); #1;
        acc = if5.move_accept;
        rej = if5.move_reject;
        if5.move_valid = 1'b0;
        lat = 0;
        while (!if5.move_ready && !go5 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (if3.move_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", if3.move_ready);
        end
        checks++;
        if (board3 !== 18'h0 || turn3 !== 1'b0 || go3 !== 1'b0 || win3 !== 2'b00 || draw3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: board=%h turn=%b over=%b winner=%b draw=%b want 0", board3, turn3, go3, win3, draw3);
        end
        checks++;
        if (if3.move_accept !== 1'b0 || if3.move_reject !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: acc=%b rej=%b want 0/0", if3.move_accept, if3.move_reject);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if3.move_ready !== 1'b1 || if5.move_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b/%b want 1/1", if3.move_ready, if5.move_ready);
        end
    endtask

    task automatic test_win_row();
        int   seq[5];
        logic acc, rej, a2, r2;
        int   lat;
        logic stuck;
        seq = '{0, 3, 1, 4, 2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mv3(seq[i], acc, rej, lat);
            checks++;
            if (acc !== 1'b1 || rej !== 1'b0) begin
                errors++; $display("FAIL win_row_accept move %0d: acc=%b rej=%b want 1/0", i, acc, rej);
            end
            checks++;
            if (lat !== 4) begin
                errors++; $display("FAIL win_row_latency move %0d: got %0d want 4", i, lat);
            end
        end
        checks++;
        if (go3 !== 1'b1 || win3 !== 2'b01 || draw3 !== 1'b0) begin
            errors++; $display("FAIL win_row_result: over=%b winner=%b draw=%b want 1/01/0", go3, win3, draw3);
        end
        checks++;
        if (board3 !== 18'h00295) begin
            errors++; $display("FAIL win_row_board: got %h want 00295", board3);
        end
        stuck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (if3.move_ready !== 1'b0) stuck = 1'b1;
        end
        checks++;
        if (stuck !== 1'b0) begin
            errors++; $display("FAIL win_row_ready_low: ready rose in OVER (got 1 want 0)");
        end
        if3.move_valid = 1'b1;
        if3.move_idx   = 4'd5;
        @(posedge clk); #1;
        a2 = if3.move_accept; r2 = if3.move_reject;
        if3.move_valid = 1'b0;
        @(posedge clk); #1;
        a2 = a2 | if3.move_accept; r2 = r2 | if3.move_reject;
        checks++;
        if (a2 !== 1'b0 || r2 !== 1'b0 || board3 !== 18'h00295 || go3 !== 1'b1) begin
            errors++; $display("FAIL over_ignore: acc=%b rej=%b board=%h over=%b want 0/0/00295/1", a2, r2, board3, go3);
        end
    endtask

    task automatic test_reject();
        logic acc, rej;
        int   lat;
        do_reset();
        mv3(4, acc, rej, lat);
        checks++;
        if (acc !== 1'b1 || lat !== 4 || turn3 !== 1'b1) begin
            errors++; $display("FAIL reject_first: acc=%b lat=%0d turn=%b want 1/4/1", acc, lat, turn3);
        end
        mv3(4, acc, rej, lat);
        checks++;
        if (acc !== 1'b0 || rej !== 1'b1 || lat !== 0) begin
            errors++; $display("FAIL reject_occupied: acc=%b rej=%b lat=%0d want 0/1/0", acc, rej, lat);
        end
        checks++;
        if (turn3 !== 1'b1 || board3 !== 18'h00100) begin
            errors++; $display("FAIL reject_unchanged: turn=%b board=%h want 1/00100", turn3, board3);
        end
        @(posedge clk); #1;
        checks++;
        if (if3.move_reject !== 1'b0) begin
            errors++; $display("FAIL reject_pulse_width: got %b want 0", if3.move_reject);
        end
        mv3(9, acc, rej, lat);
        checks++;
        if (acc !== 1'b0 || rej !== 1'b1 || board3 !== 18'h00100 || turn3 !== 1'b1) begin
            errors++; $display("FAIL reject_range9: acc=%b rej=%b board=%h turn=%b want 0/1/00100/1", acc, rej, board3, turn3);
        end
        mv3(15, acc, rej, lat);
        checks++;
        if (acc !== 1'b0 || rej !== 1'b1) begin
            errors++; $display("FAIL reject_range15: acc=%b rej=%b want 0/1", acc, rej);
        end
    endtask

    task automatic test_draw();
        int   seq[9];
        logic acc, rej;
        int   lat;
        seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            mv3(seq[i], acc, rej, lat);
            checks++;
            if (acc !== 1'b1 || lat !== 4 || go3 !== (i == 8)) begin
                errors++; $display("FAIL draw_move %0d: acc=%b lat=%0d over=%b want 1/4/%0d", i, acc, lat, go3, i == 8);
            end
        end
        checks++;
        if (draw3 !== 1'b1 || win3 !== 2'b00 || go3 !== 1'b1) begin
            errors++; $display("FAIL draw_result: draw=%b winner=%b over=%b want 1/00/1", draw3, win3, go3);
        end
        checks++;
        if (board3 !== 18'h16A59) begin
            errors++; $display("FAIL draw_board: got %h want 16a59", board3);
        end
    endtask

    task automatic play5(input string name, input int n, input int seq[8], input logic exp_over);
        logic acc, rej;
        int   lat;
        do_reset();
        for (int i = 0; i < n; i++) begin
            mv5(seq[i], acc, rej, lat);
            checks++;
            if (acc !== 1'b1 || lat !== 4 || go5 !== (exp_over && i == n - 1)) begin
                errors++; $display("FAIL %s move %0d: acc=%b lat=%0d over=%b want 1/4/%0d", name, i, acc, lat, go5, exp_over && i == n - 1);
            end
        end
        checks++;
        if (win5 !== (exp_over ? 2'b01 : 2'b00) || draw5 !== 1'b0) begin
            errors++; $display("FAIL %s result: winner=%b draw=%b want %b/0", name, win5, draw5, exp_over ? 2'b01 : 2'b00);
        end
    endtask

    task automatic test_board5();
        int s[8];
        s = '{0, 1, 6, 2, 12, 3, 18, 0};
        play5("diag5", 7, s, 1'b1);
        checks++;
        if (board5[25:24] !== 2'b01 || board5[7:6] !== 2'b10) begin
            errors++; $display("FAIL diag5_cells: c12=%b c3=%b want 01/10", board5[25:24], board5[7:6]);
        end
        s = '{20, 0, 21, 1, 22, 0, 0, 0};
        play5("row3_5", 5, s, 1'b0);
        checks++;
        if (turn5 !== 1'b1) begin
            errors++; $display("FAIL row3_5_turn: got %b want 1", turn5);
        end
        s = '{3, 10, 4, 11, 5, 15, 6, 0};
        play5("wrap5", 7, s, 1'b0);
        s = '{4, 0, 8, 1, 12, 2, 16, 0};
        play5("anti5", 7, s, 1'b1);
    endtask

    task automatic test_reset_mid_check();
        logic stuck;
        do_reset();
        if3.move_valid = 1'b1;
        if3.move_idx   = 4'd0;
        @(posedge clk); #1;
        if3.move_valid = 1'b0;
        checks++;
        if (if3.move_accept !== 1'b1) begin
            errors++; $display("FAIL midchk_accept: got %b want 1", if3.move_accept);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (if3.move_ready !== 1'b0 || board3 !== 18'h0) begin
            errors++; $display("FAIL midchk_in_reset: ready=%b board=%h want 0/0", if3.move_ready, board3);
        end
        reset = 1'b0;
        stuck = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (if3.move_ready !== 1'b1) stuck = 1'b1;
        end
        checks++;
        if (stuck !== 1'b0 || board3 !== 18'h0 || go3 !== 1'b0 || win3 !== 2'b00 || turn3 !== 1'b0) begin
            errors++;
            $display("FAIL midchk_after: ready_drop=%b board=%h over=%b winner=%b turn=%b want 0/0/0/00/0", stuck, board3, go3, win3, turn3);
        end
    endtask

`ifdef GRID_BOARD_UNDO_EN
    task automatic test_undo();
        int   seq[5];
        logic acc, rej;
        int   lat;
        seq = '{0, 3, 1, 4, 2};
        do_reset();
        for (int i = 0; i < 5; i++) mv3(seq[i], acc, rej, lat);
        checks++;
        if (go3 !== 1'b1 || ua3 !== 1'b1) begin
            errors++; $display("FAIL undo_pre: over=%b undo_avail=%b want 1/1", go3, ua3);
        end
        undo3 = 1'b1;
        @(posedge clk); #1;
        undo3 = 1'b0;
        checks++;
        if (board3 !== 18'h00285 || go3 !== 1'b0 || win3 !== 2'b00 || turn3 !== 1'b0 || ua3 !== 1'b0) begin
            errors++;
            $display("FAIL undo_first: board=%h over=%b winner=%b turn=%b avail=%b want 00285/0/00/0/0", board3, go3, win3, turn3, ua3);
        end
        checks++;
        if (if3.move_ready !== 1'b1) begin
            errors++; $display("FAIL undo_ready: got %b want 1", if3.move_ready);
        end
        undo3 = 1'b1;
        @(posedge clk); #1;
        undo3 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (board3 !== 18'h00285 || turn3 !== 1'b0 || ua3 !== 1'b0) begin
            errors++; $display("FAIL undo_second: board=%h turn=%b avail=%b want 00285/0/0", board3, turn3, ua3);
        end
    endtask
`endif

    initial begin
        reset          = 1'b1;
        if3.move_valid = 1'b0;
        if3.move_idx   = '0;
        if5.move_valid = 1'b0;
        if5.move_idx   = '0;
`ifdef GRID_BOARD_UNDO_EN
        undo3 = 1'b0;
        undo5 = 1'b0;
`endif
        #1;
        test_reset();
        test_win_row();
        test_reject();
        test_draw();
        test_board5();
        test_reset_mid_check();
`ifdef GRID_BOARD_UNDO_EN
        test_undo();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
